// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_pkg
//  Purpose  : Shared definitions for the direct-mapped instruction cache.
//             Holds the controller state encoding and the helper functions
//             that derive the address field widths from the cache parameters.
//  Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MISS_REQ  = 2'd1;
    localparam logic [1:0] S_MISS_FILL = 2'd2;

    // Byte-offset bits within one instruction word
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Word-index bits within one line
    function automatic int wrd_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-index bits
    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Remaining upper address bits form the tag
    function automatic int tag_w(input int addr_w, input int data_w,
                                 input int line_words, input int num_lines);
        return addr_w - off_w(data_w) - wrd_w(line_words) - idx_w(num_lines);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_tag_array.sv
`default_nettype none
// ============================================================================
//  Module   : icache_tag_array
//  Purpose  : Valid bits and tags of the direct-mapped instruction cache.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             lookup_idx/tag  - combinational lookup; lookup_hit when the
//                               indexed line is valid and its tag matches
//             wr_en/idx/tag/  - single write port: stores tag and valid bit
//             wr_valid          of one line
//             clear_all       - invalidates every line at the next edge
//  Revision : 1.0 - initial release
// ============================================================================
module icache_tag_array #(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lookup_idx,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_hit,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_valid,
    input  logic             clear_all
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag [NUM_LINES];

    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= wr_valid;
        end
    end

    // Tags need no reset: they are only trusted when the valid bit is set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_idx] <= wr_tag;
        end
    end

    assign lookup_hit = r_valid[lookup_idx] && (r_tag[lookup_idx] == lookup_tag);

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm
//  Purpose  : Direct-mapped instruction cache between IFetch and the
//             instruction memory bus. One-cycle hits, burst line refill,
//             whole-cache flush for fence.i.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             rx_valid/rx_ready/rx_addr - fetch request
//             tx_valid/tx_ready/tx_data - registered instruction response
//             flush                    - invalidate all lines
//             mem_req_*                - line refill request
//             mem_rsp_valid/data       - refill beats, word 0 first
//  Revision : 1.0 - initial release
// ============================================================================
module icache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] rx_addr,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);

    localparam int OFF_W = off_w(DATA_W);
    localparam int WRD_W = wrd_w(LINE_WORDS);
    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(ADDR_W, DATA_W, LINE_WORDS, NUM_LINES);
    localparam logic [WRD_W-1:0] c_LAST_WORD = WRD_W'(LINE_WORDS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_req_addr;
    logic [WRD_W-1:0]  r_cnt;
    logic              r_flush_pend;
    logic              r_tx_valid;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_mem_req_valid;
    logic [ADDR_W-1:0] r_mem_req_addr;
    logic [DATA_W-1:0] r_data [NUM_LINES][LINE_WORDS];

    logic              w_lookup_hit;
    logic              w_accept;
    logic              w_hit_load;
    logic              w_miss_start;
    logic              w_req_done;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_clear_all;
    logic              w_tag_we;

    // Address fields of the incoming request and of the latched miss
    logic [IDX_W-1:0]  w_rx_idx;
    logic [TAG_W-1:0]  w_rx_tag;
    logic [WRD_W-1:0]  w_rx_wrd;
    logic [IDX_W-1:0]  w_req_idx;
    logic [TAG_W-1:0]  w_req_tag;
    logic [WRD_W-1:0]  w_req_wrd;
    logic              w_unused;

    assign w_rx_idx  = rx_addr[OFF_W+WRD_W +: IDX_W];
    assign w_rx_tag  = rx_addr[ADDR_W-1 -: TAG_W];
    assign w_rx_wrd  = rx_addr[OFF_W +: WRD_W];
    assign w_req_idx = r_req_addr[OFF_W+WRD_W +: IDX_W];
    assign w_req_tag = r_req_addr[ADDR_W-1 -: TAG_W];
    assign w_req_wrd = r_req_addr[OFF_W +: WRD_W];
    // Byte-offset bits are never looked at
    assign w_unused  = ^{rx_addr, r_req_addr};

    icache_tag_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_tags (
        .clk        (clk),
        .rst        (rst),
        .lookup_idx (w_rx_idx),
        .lookup_tag (w_rx_tag),
        .lookup_hit (w_lookup_hit),
        .wr_en      (w_tag_we),
        .wr_idx     (w_req_idx),
        .wr_tag     (w_req_tag),
        .wr_valid   (w_last_beat),
        .clear_all  (w_clear_all)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_miss_start) w_next_state = S_MISS_REQ;
            S_MISS_REQ:  if (w_req_done)   w_next_state = S_MISS_FILL;
            S_MISS_FILL: if (w_last_beat)  w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        rx_ready     = (r_state == S_IDLE) && !flush && !r_flush_pend
                       && (!r_tx_valid || tx_ready);
        w_accept     = rx_valid && rx_ready;
        w_hit_load   = w_accept && w_lookup_hit;
        w_miss_start = w_accept && !w_lookup_hit;
        w_req_done   = (r_state == S_MISS_REQ) && mem_req_ready;
        w_beat       = (r_state == S_MISS_FILL) && mem_rsp_valid;
        w_last_beat  = w_beat && (r_cnt == c_LAST_WORD);
        // A flush deferred during a refill fires on the first idle cycle
        w_clear_all  = (r_state == S_IDLE) && (flush || r_flush_pend);
        // First beat drops the old line's valid bit, last beat sets the new one
        w_tag_we     = w_beat && ((r_cnt == '0) || w_last_beat);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_data[w_req_idx][r_cnt] <= mem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_req_addr   <= '0;
        end else begin
            if (w_req_done) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (flush && (r_state != S_IDLE)) begin
                r_flush_pend <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_flush_pend <= 1'b0;
            end
            if (w_miss_start) begin
                r_req_addr <= rx_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else if (w_hit_load) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_data[w_rx_idx][w_rx_wrd];
        end else if (w_last_beat) begin
            r_tx_valid <= 1'b1;
            // The last word is still on the bus, not yet in the array
            r_tx_data  <= (w_req_wrd == c_LAST_WORD) ? mem_rsp_data
                                                     : r_data[w_req_idx][w_req_wrd];
        end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
        end else if (w_miss_start) begin
            r_mem_req_valid <= 1'b1;
            r_mem_req_addr  <= {rx_addr[ADDR_W-1:OFF_W+WRD_W], {(OFF_W+WRD_W){1'b0}}};
        end else if (w_req_done) begin
            r_mem_req_valid <= 1'b0;
        end
    end

    assign tx_valid      = r_tx_valid;
    assign tx_data       = r_tx_data;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_dm
//  Purpose  : Directed self-checking bench for icache_dm (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_addr;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_dm #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .LINE_WORDS (4),
        .NUM_LINES  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_addr       (rx_addr),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory contents model: every word is its own address XOR a marker
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
    endfunction

    // Present a request at a negedge; return at the negedge after acceptance
    task automatic request(input logic [31:0] a);
        bit ok;
        ok       = 1'b0;
        rx_addr  = a;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rx_ready) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        rx_valid = 1'b0;
        check("rx_accept", ok, 1);
    endtask

    // Zero-wait memory: take the refill request, then stream nbeats beats
    task automatic serve_miss(input logic [31:0] line, input int nbeats, input int flush_beat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mem_req_seen", seen, 1);
        check("mem_req_addr", mem_req_addr, line);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("mem_req_dropped", mem_req_valid, 0);
        for (int k = 0; k < nbeats; k++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(line + 32'(4 * k));
            flush         = (k == flush_beat);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        flush         = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_addr = '0; tx_ready = 1'b1;
        flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        rst = 1'b0;
        #1 check("idle_rx_ready", rx_ready, 1);
        @(negedge clk);

        // Cold miss then hit
        request(32'h100);
        check("cold_tx_idle", tx_valid, 0);
        check("cold_req_valid", mem_req_valid, 1);
        serve_miss(32'h100, 4, -1);
        check("cold_tx_valid", tx_valid, 1);
        check("cold_tx_data", tx_data, mem_word(32'h100));
        @(negedge clk);
        check("cold_consumed", tx_valid, 0);
        request(32'h104);
        check("hit_tx_valid", tx_valid, 1);
        check("hit_tx_data", tx_data, mem_word(32'h104));
        check("hit_no_req", mem_req_valid, 0);
        @(negedge clk);

        // Critical word is the last beat
        request(32'h20C);
        serve_miss(32'h200, 4, -1);
        check("crit_tx_valid", tx_valid, 1);
        check("crit_tx_data", tx_data, mem_word(32'h20C));
        @(negedge clk);

        // Conflict eviction on index 0
        request(32'h000);
        serve_miss(32'h000, 4, -1);
        check("evict_fill0", tx_data, mem_word(32'h000));
        @(negedge clk);
        request(32'h100);
        check("evict_miss_100", mem_req_valid, 1);
        serve_miss(32'h100, 4, -1);
        check("evict_data_100", tx_data, mem_word(32'h100));
        @(negedge clk);
        request(32'h000);
        check("evict_miss_000", mem_req_valid, 1);
        serve_miss(32'h000, 4, -1);
        check("evict_data_000", tx_data, mem_word(32'h000));
        @(negedge clk);

        // Backpressure on a hit
        tx_ready = 1'b0;
        request(32'h004);
        for (int i = 0; i < 5; i++) begin
            check("bp_tx_valid", tx_valid, 1);
            check("bp_tx_data", tx_data, mem_word(32'h004));
            rx_valid = 1'b1;
            rx_addr  = 32'h008;
            #1 check("bp_rx_ready", rx_ready, 0);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_released", tx_valid, 0);

        // Four back-to-back hits on line 0x000
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                check("tp_tx_valid", tx_valid, 1);
                check("tp_tx_data", tx_data, mem_word(32'(4 * (i - 1))));
            end
            if (i < 4) begin
                rx_addr  = 32'(4 * i);
                rx_valid = 1'b1;
                #1 check("tp_rx_ready", rx_ready, 1);
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("tp_drained", tx_valid, 0);

        // Flush during refill: response delivered, line invalid afterwards
        request(32'h300);
        serve_miss(32'h300, 4, 1);
        check("fl_tx_valid", tx_valid, 1);
        check("fl_tx_data", tx_data, mem_word(32'h300));
        #1 check("fl_pend_blocks", rx_ready, 0);
        @(negedge clk);
        request(32'h300);
        check("fl_post_miss", mem_req_valid, 1);
        serve_miss(32'h300, 4, -1);
        @(negedge clk);

        // Flush in idle wins over a simultaneous request
        flush    = 1'b1;
        rx_valid = 1'b1;
        rx_addr  = 32'h304;
        #1 check("idle_flush_rx_ready", rx_ready, 0);
        @(negedge clk);
        flush    = 1'b0;
        rx_valid = 1'b0;
        request(32'h304);
        check("idle_flush_miss", mem_req_valid, 1);
        serve_miss(32'h300, 4, -1);
        check("idle_flush_data", tx_data, mem_word(32'h304));
        @(negedge clk);

        // Reset in the middle of a refill
        request(32'h040);
        serve_miss(32'h040, 3, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_req_valid", mem_req_valid, 0);
        @(negedge clk);
        request(32'h040);
        check("mid_rst_miss", mem_req_valid, 1);
        serve_miss(32'h040, 4, -1);
        check("mid_rst_data", tx_data, mem_word(32'h040));
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
